io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Byte-oriented serial transmitter peripheral that sits directly downstream of the I/O port decoder, attached to one 8-bit I/O port slot.
- CPU writes to the slot push bytes into a small TX FIFO.
- CPU reads of the slot return a status byte.
- Bytes are serialised 8N1 (start, 8 data LSB-first, stop) on a single output line at a parameterised bit period.

Parameters:
- CLK_DIV, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr  input  1  write strobe for this slot, one cycle per byte; driven from the decoder's write qualifier for this address.
- rd  input  1  status-read strobe for this slot, one cycle per read.
- din  input  8  byte to transmit; sampled when wr=1.
- dout  output  8  status byte, registered.
- txd  output  1  serial line; idles high.
- irq  output  1  high while the FIFO has space and overflow=0.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge):
  - FIFO emptied.
  - FSM to IDLE.
  - txd=1.
  - dout=8'h02 (empty=1).
  - overflow=0.
  - Baud counter and bit counter 0.
  - irq=1 from the first cycle after reset.
- Reset mid-frame aborts the frame. txd returns high on the edge where rst_n=0 is sampled. No partial-frame completion.
- Status byte:
  - bit0 full.
  - bit1 empty.
  - bit2 busy (FSM not IDLE).
  - bit3 overflow (sticky).
  - bits7:4 FIFO occupancy count, saturating at 15.
- dout is updated every cycle from current state, so it reflects state one cycle late.
- rd=1: after the edge, overflow clears. dout on that edge still shows overflow=1, so the read that observes the flag clears it.
- FIFO:
  - Push on wr=1 when not full.
  - wr=1 while full with no simultaneous pop: byte dropped, overflow set to 1, FIFO unchanged.
  - wr=1 while full in the same cycle as an FSM pop: push accepted, occupancy unchanged.
  - Simultaneous wr and rd are independent: push is processed and overflow clears, unless that same write overflows, in which case overflow=1 wins.
  - Read/write pointers wrap modulo FIFO_DEPTH. Occupancy counter is one bit wider than the pointers.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If FIFO non-empty at an edge: pop the head into the shift register, clear the baud counter, go to START.
  - txd goes 0 after that edge.
- START:
  - txd=0 for CLK_DIV cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - txd=shift[0] for CLK_DIV cycles per bit.
  - Shift right after each bit.
  - After bit index 7, go to STOP.
- STOP:
  - txd=1 for CLK_DIV cycles.
  - At the final cycle: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length is exactly 10*CLK_DIV cycles.
- Latency: a wr at edge N into an empty FIFO with FSM idle gives txd=0 starting after edge N+1.
- Baud counter runs 0..CLK_DIV-1 and resets at each bit boundary. It never free-runs in IDLE.
- busy=1 from the edge leaving IDLE to the edge entering IDLE.

Test Plan:
1. Reset then idle, CLK_DIV=4 -> txd=1, dout=8'h02, irq=1, steady for 100 cycles.
2. Single byte, CLK_DIV=4: wr din=8'hA5 at edge N -> txd low for cycles N+1..N+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop high for 4 cycles. busy falls after edge N+41. Total frame 40 cycles.
3. Back-to-back: push 8'h00 and 8'hFF on consecutive cycles -> two frames with no gap. The second start bit begins exactly 40 cycles after the first. Mid-frame status reads 8'h14 (count 1, busy).
4. Overflow, FIFO_DEPTH=4: push 6 bytes on consecutive cycles while the first frame is running (1 popped) -> bytes 1..5 accepted and the 6th dropped. Status reads full=1, overflow=1, count=4, so dout=8'h4D. irq=0. Next rd shows overflow=0.
5. Full-plus-pop: FIFO full with wr coinciding with the STOP-to-START pop -> byte accepted, count stays 4, overflow stays 0.
6. Reset mid-frame: assert rst_n=0 during DATA bit 3 -> txd=1 next cycle, FIFO empty, dout=8'h02. A queued byte is never sent.

Source files
------------

// File: rtl/io_uart_tx.sv
// io_uart_tx: 8N1 serial transmitter on one I/O port slot.
// CPU writes push bytes into a small TX FIFO; CPU reads return a status byte
// {count[3:0], overflow, busy, empty, full}. txd idles high.
module io_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       txd,
  output logic       irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    dout_q, status_d;

  logic          full, empty, baud_end, pop, push;
  logic [4:0]    occ5;
  logic [3:0]    occ_sat;
  logic [7:0]    head;

  // FIFO control, overflow flag and status byte next-state
  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    baud_end = (baud_q == BAUD_LAST);
    head     = mem_q[rd_ptr_q];
    // The FSM takes the head either from IDLE or on the last STOP cycle,
    // so back-to-back frames leave no idle gap.
    pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
    // A write to a full FIFO still fits when a pop frees a slot this cycle.
    push     = wr && (!full || pop);

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    // A dropped write outranks a simultaneous status read.
    ovf_d = ovf_q;
    if (rd) begin
      ovf_d = 1'b0;
    end
    if (wr && !push) begin
      ovf_d = 1'b1;
    end

    occ5     = 5'(count_q);
    occ_sat  = occ5[4] ? 4'hF : occ5[3:0];
    status_d = {occ_sat, ovf_q, (state_q != S_IDLE), empty, full};
  end

  // FIFO storage (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // FIFO pointers, occupancy, overflow flag and registered status byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      dout_q   <= 8'h02;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
      dout_q  <= status_d;
    end
  end

  // Serialiser FSM: start bit, 8 data bits LSB-first, stop bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= head;
              txd_q   <= 1'b0;
              state_q <= S_START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          baud_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign txd  = txd_q;
  assign dout = dout_q;
  assign irq  = !full && !ovf_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed self-checking bench for io_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_io_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       txd;
  logic       irq;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  io_uart_tx #(
    .CLK_DIV   (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wr   (wr),
    .rd   (rd),
    .din  (din),
    .dout (dout),
    .txd  (txd),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected txd k cycles into a frame (k=1 is the cycle after the start edge).
  function automatic logic exp_txd(input logic [7:0] b, input int k);
    if (k <= 4) return 1'b0;
    else if (k <= 36) return b[(k - 5) / 4];
    else return 1'b1;
  endfunction

  // Called right after the edge that starts a frame; returns after frame end edge.
  task automatic expect_frame(input logic [7:0] b, input int mid_k,
                              input logic [7:0] mid_val, input string tag);
    for (int k = 1; k <= 40; k++) begin
      check($sformatf("%s_txd%0d", tag, k), {7'b0, txd}, {7'b0, exp_txd(b, k)});
      if (k == mid_k) check({tag, "_status"}, dout, mid_val);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = 8'h00;
    tick();
    tick();

    // 1: reset state and idle stability
    check("rst_txd", {7'b0, txd}, 8'h01);
    check("rst_dout", dout, 8'h02);
    check("rst_irq", {7'b0, irq}, 8'h01);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_txd", {7'b0, txd}, 8'h01);
      check("idle_dout", dout, 8'h02);
      check("idle_irq", {7'b0, irq}, 8'h01);
    end

    // 2: single byte A5
    din = 8'hA5;
    wr  = 1'b1;
    tick();                       // edge N
    wr = 1'b0;
    check("t2_latency", {7'b0, txd}, 8'h01);
    tick();                       // edge N+1: start bit begins
    expect_frame(8'hA5, 2, 8'h06, "t2");
    check("t2_end_txd", {7'b0, txd}, 8'h01);
    check("t2_end_busy", dout, 8'h06);
    tick();
    check("t2_idle_dout", dout, 8'h02);

    // 3: back-to-back 00 then FF, no gap
    din = 8'h00;
    wr  = 1'b1;
    tick();                       // edge N
    din = 8'hFF;
    tick();                       // edge N+1: pop 00, push FF
    wr = 1'b0;
    expect_frame(8'h00, 10, 8'h14, "t3a");
    expect_frame(8'hFF, 0, 8'h00, "t3b");
    check("t3_end_txd", {7'b0, txd}, 8'h01);
    tick();
    check("t3_idle_dout", dout, 8'h02);

    // 4/5/6: overflow, full-plus-pop, reset mid-frame
    din = 8'h11;
    wr  = 1'b1;
    tick();                       // edge N: push 11
    for (int k = 1; k <= 57; k++) begin
      wr  = (k <= 5) || (k == 41);
      din = (k <= 5) ? 8'(8'h11 * (k + 1)) : 8'h77;
      rd  = (k == 7);
      tick();                     // edge N+k
      if (k <= 40)
        check($sformatf("t4_txd%0d", k), {7'b0, txd}, {7'b0, exp_txd(8'h11, k)});
      else
        check($sformatf("t5_txd%0d", k), {7'b0, txd}, {7'b0, exp_txd(8'h22, k - 40)});
      case (k)
        5: check("t4_irq_full", {7'b0, irq}, 8'h00);
        6: begin
          check("t4_ovf_status", dout, 8'h4D);
          check("t4_irq_ovf", {7'b0, irq}, 8'h00);
        end
        7: check("t4_rd_sees_ovf", dout, 8'h4D);
        8: begin
          check("t4_ovf_cleared", dout, 8'h45);
          check("t4_irq_still_full", {7'b0, irq}, 8'h00);
        end
        42: begin
          check("t5_full_pop_status", dout, 8'h45);
          check("t5_irq", {7'b0, irq}, 8'h00);
        end
        default: ;
      endcase
    end
    wr = 1'b0;
    rd = 1'b0;

    // reset sampled during data bit 3 of the 22 frame
    rst_n = 1'b0;
    tick();
    check("t6_txd", {7'b0, txd}, 8'h01);
    check("t6_dout", dout, 8'h02);
    check("t6_irq", {7'b0, irq}, 8'h01);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("t6_quiet_txd", {7'b0, txd}, 8'h01);
      check("t6_quiet_dout", dout, 8'h02);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
